// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path types for the PC redirect sequencer.
package riscv_ctrl_pkg;

   localparam int unsigned DRAIN_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } redir_state_t;

   typedef enum logic [1:0] {
      REDIR_SRC_NONE,
      REDIR_SRC_TRAP,
      REDIR_SRC_JMP,
      REDIR_SRC_BR
   } redir_src_t;

endpackage

// File: rtl/redirect_prio_arb.sv
// Combinational trap > jump > branch selection of the redirect source.
// Flags misaligned jump/branch targets when REDIRECT_MISALIGN_EN is defined.
module redirect_prio_arb
   import riscv_ctrl_pkg::*;
(
   input  logic        jmp_vld,
   input  logic [31:0] jmp_addr,
   input  logic        br_vld,
   input  logic [31:0] br_addr,
   input  logic        trap_vld,
   input  logic [31:0] trap_addr,
   output logic        req_vld,
   output logic [31:0] req_addr,
   output redir_src_t  req_src,
   output logic        misalign
);

   always_comb begin
      req_vld  = 1'b0;
      req_addr = '0;
      req_src  = REDIR_SRC_NONE;
      if (trap_vld) begin
         req_vld  = 1'b1;
         req_addr = trap_addr;
         req_src  = REDIR_SRC_TRAP;
      end else if (jmp_vld) begin
         req_vld  = 1'b1;
         req_addr = jmp_addr;
         req_src  = REDIR_SRC_JMP;
      end else if (br_vld) begin
         req_vld  = 1'b1;
         req_addr = br_addr;
         req_src  = REDIR_SRC_BR;
      end
   end

`ifdef REDIRECT_MISALIGN_EN
   // Trap targets are trusted; only EXE-resolved targets are checked.
   assign misalign = (req_src == REDIR_SRC_JMP || req_src == REDIR_SRC_BR) && req_addr[1];
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: rtl/redirect_ctrl.sv
// PC redirect sequencer: arbitrates EXE/trap redirects, flushes IF/ID, issues to fetch, drains.
// Optional misaligned-target exception via REDIRECT_MISALIGN_EN.
module redirect_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jmp_vld_i,
   input  logic [31:0] jmp_addr_i,
   input  logic        br_vld_i,
   input  logic [31:0] br_addr_i,
   input  logic        trap_vld_i,
   input  logic [31:0] trap_addr_i,
   input  logic        redirect_rdy_i,
   output logic        redirect_vld_o,
   output logic [31:0] redirect_addr_o,
   output logic        flush_if_o,
   output logic        flush_id_o,
   output logic        busy_o,
   output logic        misalign_exc_o,
   output logic [31:0] misalign_addr_o
);

   redir_state_t           state, state_nxt;
   logic [DRAIN_CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]            addr_q, addr_nxt;
   logic                   accept;
   logic                   req_vld, misalign;
   logic [31:0]            req_addr;
   redir_src_t             req_src;

   redirect_prio_arb u_arb (
      .jmp_vld   (jmp_vld_i),
      .jmp_addr  (jmp_addr_i),
      .br_vld    (br_vld_i),
      .br_addr   (br_addr_i),
      .trap_vld  (trap_vld_i),
      .trap_addr (trap_addr_i),
      .req_vld   (req_vld),
      .req_addr  (req_addr),
      .req_src   (req_src),
      .misalign  (misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         addr_q <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = addr_q;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (req_vld && !misalign) begin
               accept    = 1'b1;
               addr_nxt  = {req_addr[31:1], 1'b0};
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // A trap outranks a same-cycle fetch acceptance: old target is dropped.
            if (req_src == REDIR_SRC_TRAP) begin
               accept   = 1'b1;
               addr_nxt = {req_addr[31:1], 1'b0};
            end else if (redirect_rdy_i) begin
               cnt_nxt   = DRAIN_CNT_W'(DRAIN_CYCLES);
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (req_src == REDIR_SRC_TRAP) begin
               accept    = 1'b1;
               addr_nxt  = {req_addr[31:1], 1'b0};
               cnt_nxt   = '0;
               state_nxt = ISSUE;
            end else begin
               cnt_nxt = cnt - DRAIN_CNT_W'(1);
               if (cnt <= DRAIN_CNT_W'(1)) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign redirect_vld_o  = (state == ISSUE);
   assign redirect_addr_o = addr_q;
   assign busy_o          = (state != IDLE);
   assign flush_if_o      = accept || (state != IDLE);
   assign flush_id_o      = accept || (state != IDLE);

`ifdef REDIRECT_MISALIGN_EN
   logic        exc_q;
   logic [31:0] maddr_q;
   logic        take_exc;

   assign take_exc = (state == IDLE) && misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_q   <= 1'b0;
         maddr_q <= '0;
      end else begin
         exc_q <= take_exc;
         if (take_exc) begin
            maddr_q <= req_addr;
         end
      end
   end

   assign misalign_exc_o  = exc_q;
   assign misalign_addr_o = maddr_q;
`else
   assign misalign_exc_o  = 1'b0;
   assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: directed scenarios plus a randomized run vs. a timeline model.
// Misalign expectations follow REDIRECT_MISALIGN_EN.
module tb_redirect_ctrl;

   localparam int unsigned D = 3;
`ifdef REDIRECT_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jmp_vld, br_vld, trap_vld, rdy;
   logic [31:0] jmp_addr, br_addr, trap_addr;
   logic        redirect_vld, flush_if, flush_id, busy, misalign_exc;
   logic [31:0] redirect_addr, misalign_addr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   redirect_ctrl #(.DRAIN_CYCLES(D)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .jmp_vld_i       (jmp_vld),
      .jmp_addr_i      (jmp_addr),
      .br_vld_i        (br_vld),
      .br_addr_i       (br_addr),
      .trap_vld_i      (trap_vld),
      .trap_addr_i     (trap_addr),
      .redirect_rdy_i  (rdy),
      .redirect_vld_o  (redirect_vld),
      .redirect_addr_o (redirect_addr),
      .flush_if_o      (flush_if),
      .flush_id_o      (flush_id),
      .busy_o          (busy),
      .misalign_exc_o  (misalign_exc),
      .misalign_addr_o (misalign_addr)
   );

   task automatic drive(input logic j, input logic [31:0] ja, input logic b, input logic [31:0] ba,
                        input logic t, input logic [31:0] ta, input logic r);
      jmp_vld = j; jmp_addr = ja; br_vld = b; br_addr = ba;
      trap_vld = t; trap_addr = ta; rdy = r;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0) done = 1'b1;
         else next_cycle();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after 50 cycles, required 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      drive(0, '0, 0, '0, 0, '0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({redirect_vld, flush_if, flush_id, busy, misalign_exc} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: vld/fif/fid/busy/exc=%b required 00000",
                  {redirect_vld, flush_if, flush_id, busy, misalign_exc});
      end
      checks++;
      if (redirect_addr !== 32'h0 || misalign_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: addr=%h maddr=%h required 0/0", redirect_addr, misalign_addr);
      end
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_jump();
      drive(1, 32'h0000_1000, 0, '0, 0, '0, 1);
      @(negedge clk);
      checks++;
      if (flush_if !== 1'b1 || flush_id !== 1'b1 || redirect_vld !== 1'b0) begin
         errors++;
         $display("FAIL jump_n: fif=%b fid=%b vld=%b required 1 1 0", flush_if, flush_id, redirect_vld);
      end
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1 || redirect_addr !== 32'h0000_1000) begin
         errors++;
         $display("FAIL jump_issue: vld=%b addr=%h required 1 00001000", redirect_vld, redirect_addr);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b0 || busy !== 1'b1 || flush_if !== 1'b1) begin
         errors++;
         $display("FAIL jump_drain: vld=%b busy=%b fif=%b required 0 1 1", redirect_vld, busy, flush_if);
      end
      for (int k = 0; k < int'(D) - 1; k++) begin
         next_cycle();
         @(negedge clk);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL jump_drain_len: busy=%b at drain cycle %0d required 1", busy, k + 2);
         end
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || flush_if !== 1'b0 || flush_id !== 1'b0) begin
         errors++;
         $display("FAIL jump_idle: busy=%b fif=%b fid=%b required 0 0 0", busy, flush_if, flush_id);
      end
      next_cycle();
   endtask

   task automatic test_backpressure();
      drive(0, '0, 1, 32'h0000_0200, 0, '0, 0);
      @(negedge clk);
      checks++;
      if (flush_if !== 1'b1) begin
         errors++;
         $display("FAIL bp_flush_n: fif=%b required 1", flush_if);
      end
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (redirect_vld !== 1'b1 || redirect_addr !== 32'h200 || flush_if !== 1'b1 || flush_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d vld=%b addr=%h fif=%b fid=%b required 1 00000200 1 1",
                     i, redirect_vld, redirect_addr, flush_if, flush_id);
         end
         next_cycle();
      end
      rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1) begin
         errors++;
         $display("FAIL bp_accept: vld=%b required 1", redirect_vld);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b0 || flush_if !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_once: vld=%b fif=%b busy=%b required 0 1 1", redirect_vld, flush_if, busy);
      end
      wait_idle();
   endtask

   task automatic test_arbitration();
      int seen;
      drive(1, 32'h0000_0100, 0, '0, 1, 32'h8000_0000, 1);
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1 || redirect_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL arb_trap_prio: vld=%b addr=%h required 1 80000000", redirect_vld, redirect_addr);
      end
      next_cycle();
      drive(1, 32'h0000_0300, 0, '0, 0, '0, 1);
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      seen = 0;
      for (int i = 0; i < int'(D) + 3; i++) begin
         @(negedge clk);
         if (redirect_vld === 1'b1) seen++;
         next_cycle();
      end
      checks++;
      if (seen != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL arb_drain_jump: issued %0d times busy=%b required 0 0", seen, busy);
      end
      drive(1, 32'h0000_0400, 0, '0, 0, '0, 1);
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      next_cycle();
      drive(0, '0, 0, '0, 1, 32'h0000_0501, 0);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b0 || flush_if !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL arb_drain_trap_n: vld=%b fif=%b busy=%b required 0 1 1", redirect_vld, flush_if, busy);
      end
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 0);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1 || redirect_addr !== 32'h0000_0500) begin
         errors++;
         $display("FAIL arb_drain_trap: vld=%b addr=%h required 1 00000500", redirect_vld, redirect_addr);
      end
      rdy = 1'b1;
      next_cycle();
      wait_idle();
   endtask

   task automatic test_odd_target();
      drive(1, 32'h0000_2003, 0, '0, 0, '0, 1);
      @(negedge clk);
`ifdef REDIRECT_MISALIGN_EN
      checks++;
      if (flush_if !== 1'b0 || flush_id !== 1'b0) begin
         errors++;
         $display("FAIL odd_noflush: fif=%b fid=%b required 0 0", flush_if, flush_id);
      end
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      @(negedge clk);
      checks++;
      if (misalign_exc !== 1'b1 || misalign_addr !== 32'h0000_2003 || redirect_vld !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL odd_exc: exc=%b maddr=%h vld=%b busy=%b required 1 00002003 0 0",
                  misalign_exc, misalign_addr, redirect_vld, busy);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (misalign_exc !== 1'b0 || misalign_addr !== 32'h0000_2003) begin
         errors++;
         $display("FAIL odd_pulse: exc=%b maddr=%h required 0 00002003", misalign_exc, misalign_addr);
      end
      next_cycle();
`else
      checks++;
      if (flush_if !== 1'b1) begin
         errors++;
         $display("FAIL odd_flush: fif=%b required 1", flush_if);
      end
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1 || redirect_addr !== 32'h0000_2002 || misalign_exc !== 1'b0 || misalign_addr !== 32'h0) begin
         errors++;
         $display("FAIL odd_issue: vld=%b addr=%h exc=%b maddr=%h required 1 00002002 0 0",
                  redirect_vld, redirect_addr, misalign_exc, misalign_addr);
      end
      next_cycle();
      wait_idle();
`endif
   endtask

   task automatic test_reset_mid_issue();
      drive(1, 32'h0000_3000, 0, '0, 0, '0, 0);
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 0);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: vld=%b required 1", redirect_vld);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({redirect_vld, flush_if, flush_id, busy, misalign_exc} !== 5'b0 || redirect_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_async: flags=%b addr=%h required 00000 0",
                  {redirect_vld, flush_if, flush_id, busy, misalign_exc}, redirect_addr);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_dropped: vld=%b busy=%b required 0 0", redirect_vld, busy);
      end
      next_cycle();
      drive(1, 32'h0000_4000, 0, '0, 0, '0, 1);
      next_cycle();
      drive(0, '0, 0, '0, 0, '0, 1);
      @(negedge clk);
      checks++;
      if (redirect_vld !== 1'b1 || redirect_addr !== 32'h0000_4000) begin
         errors++;
         $display("FAIL rst_mid_after: vld=%b addr=%h required 1 00004000", redirect_vld, redirect_addr);
      end
      next_cycle();
      wait_idle();
   endtask

   // Model: one outstanding target plus the cycle number at which EXE redirects are welcome again.
   task automatic test_random();
      bit          pending = 1'b0;
      bit          exc = 1'b0, exc_next;
      logic [31:0] target = '0, maddr = '0, sel;
      int          cyc = 0, idle_at = 0;
      bit          j, b, t, r, exp_busy, odd, exe_take, exp_flush;
      logic [31:0] ja, ba, ta;

      drive(0, '0, 0, '0, 0, '0, 0);
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      for (int n = 0; n < 400; n++) begin
         j  = ($urandom_range(0, 3) == 0);
         b  = ($urandom_range(0, 3) == 0);
         t  = ($urandom_range(0, 15) == 0);
         r  = ($urandom_range(0, 1) == 1);
         ja = $urandom; ba = $urandom; ta = $urandom;
         drive(j, ja, b, ba, t, ta, r);
         @(negedge clk);

         sel       = j ? ja : ba;
         odd       = MIS_EN && sel[1];
         exp_busy  = pending || (cyc < idle_at);
         exe_take  = !exp_busy && !t && (j || b) && !odd;
         exp_flush = exp_busy || t || exe_take;

         checks++;
         if (redirect_vld !== pending || redirect_addr !== target) begin
            errors++;
            $display("FAIL rand_redirect: cycle %0d vld=%b addr=%h required %b %h",
                     n, redirect_vld, redirect_addr, pending, target);
         end
         checks++;
         if (busy !== exp_busy || flush_if !== exp_flush || flush_id !== exp_flush) begin
            errors++;
            $display("FAIL rand_ctrl: cycle %0d busy=%b fif=%b fid=%b required %b %b %b",
                     n, busy, flush_if, flush_id, exp_busy, exp_flush, exp_flush);
         end
         checks++;
         if (misalign_exc !== exc || misalign_addr !== maddr) begin
            errors++;
            $display("FAIL rand_misalign: cycle %0d exc=%b maddr=%h required %b %h",
                     n, misalign_exc, misalign_addr, exc, maddr);
         end

         exc_next = 1'b0;
         if (t) begin
            target  = ta & ~32'h1;
            pending = 1'b1;
         end else if (pending && r) begin
            pending = 1'b0;
            idle_at = cyc + 1 + int'(D);
         end else if (!exp_busy && (j || b)) begin
            if (odd) begin
               exc_next = 1'b1;
               maddr    = sel;
            end else begin
               target  = sel & ~32'h1;
               pending = 1'b1;
            end
         end
         exc = exc_next;
         cyc++;
         next_cycle();
      end
      drive(0, '0, 0, '0, 0, '0, 1);
      wait_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_jump();
      test_backpressure();
      test_arbitration();
      test_odd_target();
      test_reset_mid_issue();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Sequences PC redirects from the EXE stage (JAL/JALR jump unit, branch unit) and from the trap unit into the fetch stage. Arbitrates simultaneous redirect sources, drives IF/ID flush, holds the redirect until fetch accepts it, then drains the pipeline for a fixed bubble count before accepting new EXE redirects. Sits between the EXE-stage jump/branch units and the IF-stage PC register.

## Interface
- `DRAIN_CYCLES`, 1: bubble cycles after fetch acceptance before returning to IDLE (1..15).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `jmp_vld_i` in 1: jump redirect request (JAL or JALR resolved in EXE).
- `jmp_addr_i` in 32: jump target.
- `br_vld_i` in 1: taken-branch redirect request.
- `br_addr_i` in 32: branch target.
- `trap_vld_i` in 1: trap/mret redirect request.
- `trap_addr_i` in 32: trap vector or mepc.
- `redirect_rdy_i` in 1: IF accepts the redirect this cycle.
- `redirect_vld_o` out 1: redirect pending toward IF.
- `redirect_addr_o` out 32: redirect target, bit 0 always 0.
- `flush_if_o`, `flush_id_o` out 1: kill younger instructions in IF / ID.
- `busy_o` out 1: state != IDLE.
- `misalign_exc_o` out 1: misaligned-target exception pulse (only with `REDIRECT_MISALIGN_EN`).
- `misalign_addr_o` out 32: offending target (only with `REDIRECT_MISALIGN_EN`).

## Operation
- States: IDLE, ISSUE, DRAIN.
- Priority: trap > jump > branch. Jump and branch together should not occur; if they do, jump wins.
- IDLE: any accepted request latches the target with bit 0 forced to 0, then goes to ISSUE.
- ISSUE: hold `redirect_vld_o` until `redirect_rdy_i`. On acceptance, load the drain counter with `DRAIN_CYCLES` and go to DRAIN.
- DRAIN: decrement the counter each cycle. Go to IDLE when the counter reaches 0.
- Jump and branch requests are ignored in ISSUE and DRAIN because they come from the wrong path.
- A trap request is always accepted:
  - In ISSUE, it overwrites the target and stays in ISSUE.
  - In DRAIN, it reloads the target and returns to ISSUE.
- A trap and `redirect_rdy_i` in the same ISSUE cycle: the trap wins. The old target counts as consumed, and the trap target issues next cycle.
- Flush:
  - `flush_if_o` and `flush_id_o` are combinational in the cycle a request is accepted.
  - They are registered high throughout ISSUE and DRAIN.

## Timing
- Reset values: `redirect_vld_o`=0, `redirect_addr_o`=0, flush outputs=0, `busy_o`=0, `misalign_exc_o`=0, `misalign_addr_o`=0, state=IDLE, counter=0.
- Request accepted at cycle N: flush high at N; `redirect_vld_o` high from N+1.
- `redirect_rdy_i` at cycle M: `redirect_vld_o` low at M+1; DRAIN spans M+1..M+DRAIN_CYCLES; IDLE at M+DRAIN_CYCLES+1.
- Minimum request-to-request spacing for EXE redirects: DRAIN_CYCLES+2 cycles.
- Reset asserted mid-operation: all state clears immediately, and any pending redirect is dropped.

## Configuration
- `REDIRECT_MISALIGN_EN` defined:
  - A jump or branch target with bit 1 set is not redirected.
  - `misalign_exc_o` pulses one cycle at N+1, and `misalign_addr_o` holds the target until the next exception.
  - State stays IDLE and no flush is asserted; the trap unit issues the subsequent trap redirect.
  - Trap targets are never checked.
- Macro undefined: there is no check, `misalign_exc_o` and `misalign_addr_o` are tied to 0, and the target is issued with bit 0 cleared.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - state enum `redir_state_t` (IDLE/ISSUE/DRAIN);
  - source codes `REDIR_SRC_TRAP`/`REDIR_SRC_JMP`/`REDIR_SRC_BR`;
  - `DRAIN_CNT_W`=4.
- Sub-module `redirect_prio_arb`: combinational priority select of the valid/address source, plus the misalign check.

## Test plan
- Jump redirect: `jmp_vld_i` to 0x0000_1000 at N, `redirect_rdy_i` tied 1 → flush at N; `redirect_vld_o` with 0x0000_1000 at N+1 only; `busy_o` low at N+3 (DRAIN_CYCLES=1).
- Fetch backpressure: branch to 0x200, `redirect_rdy_i` low for 3 cycles → `redirect_vld_o` and address 0x200 held stable 3 cycles; one acceptance; flush high throughout.
- Arbitration:
  - Trap 0x8000_0000 together with jump 0x100 → only 0x8000_0000 issued.
  - Jump request during DRAIN → ignored.
  - Trap during DRAIN → returns to ISSUE with the trap target.
- JALR odd target: jump to 0x0000_2003, macro off → address 0x0000_2002. Macro on → no redirect, `misalign_exc_o` one cycle, `misalign_addr_o`=0x0000_2003.
- Reset mid-ISSUE: `rst_n` low while `redirect_vld_o`=1 → all outputs 0 asynchronously. After release, IDLE, and a new jump is accepted normally.
